axi_stream_slave: RTL and testbench
===================================

# axi_stream_slave

Receive-side AXI-Stream endpoint for the message-authentication datapath. It accepts beats from an upstream AXI-Stream master into a 2-entry skid buffer with a registered `s_ready`, and presents them to the downstream hashing/MAC core over a valid/ready interface. It also tracks message boundaries via `last`, counts beats per message, and flags upstream handshake violations.

## Interface
- `DATA_WIDTH`, 512: beat width in bits.
- `CNT_WIDTH`, 16: width of the per-message beat counter.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `resetN` in 1: asynchronous, active-low reset.
- `s_valid` in 1: upstream beat valid.
- `s_ready` out 1: registered ready to upstream.
- `s_data` in `DATA_WIDTH`: upstream beat data.
- `s_last` in 1: final beat of message (`AXIS_RX_LAST_EN` only).
- `m_valid` out 1: beat available to core.
- `m_ready` in 1: core accepts beat.
- `m_data` out `DATA_WIDTH`: head-of-buffer data.
- `m_last` out 1: head beat is final (`AXIS_RX_LAST_EN` only).
- `msg_done` out 1: one-cycle pulse after a last beat is popped (`AXIS_RX_LAST_EN` only).
- `msg_beats` out `CNT_WIDTH`: beat count of the completed message (`AXIS_RX_LAST_EN` only).
- `proto_err` out 1: sticky upstream protocol-violation flag.

## Operation
- Push = `s_valid & s_ready`. Pop = `m_valid & m_ready`.
- Occupancy states: EMPTY (0), ONE (1), FULL (2).
  - EMPTY→ONE on push.
  - ONE→FULL on push without pop.
  - ONE→EMPTY on pop without push.
  - FULL→ONE on pop.
  - Push and pop together hold the state.
- Buffer is FIFO-ordered: `m_data`/`m_last` always show the oldest entry.
- `m_valid` = (occupancy != EMPTY).
- `s_ready` is registered: next value = (next occupancy != FULL). A push can never occur while FULL.
- Beat counter (`AXIS_RX_LAST_EN`):
  - Increments on each pop and saturates at 2^CNT_WIDTH−1.
  - On a pop with `m_last`=1: `msg_beats` <= counter+1 (saturating), `msg_done` pulses next cycle, counter clears to 0.
- `proto_err` sets when, in the previous cycle, `s_valid`=1 and `s_ready`=0, and in this cycle either `s_valid`=0 or `s_data`/`s_last` differ from the previous cycle. It is cleared only by reset.

## Timing
- Reset values:
  - `s_ready`=0 during reset; it rises on the first clock edge after `resetN` deasserts.
  - `m_valid`=0, `m_data`=0, `m_last`=0, `msg_done`=0, `msg_beats`=0, `proto_err`=0.
  - Occupancy is EMPTY and the counter is 0.
- Latency: a beat pushed at edge N is visible on `m_data` with `m_valid`=1 after edge N (one cycle) when the buffer was EMPTY.
- Throughput: one beat per cycle sustained while `m_ready`=1.
- Backpressure: with `m_ready`=0, two beats are accepted, then `s_ready` drops after the edge that fills the buffer.
- `s_ready` re-asserts the cycle after the first pop from FULL.
- A simultaneous push and pop in ONE keeps `m_valid` high, and the head advances to the new beat.
- Reset mid-message discards buffered beats and the partial count, with no `msg_done`.
- Single-beat message (`s_last` on the first beat) gives `msg_beats`=1.

## Configuration
- `AXIS_RX_LAST_EN` defined:
  - `s_last`, `m_last`, `msg_done` and `msg_beats` exist.
  - The buffer stores `DATA_WIDTH+1` bits per entry.
  - The counter logic is built.
- Not defined:
  - Those ports and the counter are absent.
  - Entries are `DATA_WIDTH` bits.
  - `proto_err` compares `s_data` only.

## Structure
- Shared package `axis_pkg` holds:
  - the occupancy enum `axis_occ_e` (EMPTY, ONE, FULL);
  - the default `DATA_WIDTH`/`CNT_WIDTH` constants;
  - the beat struct (data plus optional last).
- One natural sub-module: `axis_skid_buffer` (2-entry storage, occupancy FSM, registered ready). The top adds the counter and the protocol checker.

## Test plan
- Reset release, `s_valid`=0: `s_ready` goes 0→1 one edge after `resetN` rises; `m_valid`=0.
- Stream 8 beats (data 0x1..0x8) with `m_ready`=1: `m_data` presents 0x1..0x8 on consecutive cycles, 1-cycle latency, no stalls.
- Hold `m_ready`=0 and drive 3 beats: 2 accepted, `s_ready`=0 after the second; raising `m_ready` drains 0x1, 0x2, then 0x3 in order.
- 5-beat message, `s_last` on beat 5: `msg_done` pulses once, `msg_beats`=5, and the counter restarts at 0 for the next message.
- While `s_ready`=0, drop `s_valid` before acceptance: `proto_err`=1 and stays 1 until `resetN` is pulsed.
- Assert `resetN`=0 with 2 beats buffered: `m_valid`=0 immediately, buffered beats lost, `msg_beats` stays 0.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types and default widths for the AXI-Stream receive endpoint.
// The AXIS_RX_LAST_EN macro selects whether beats carry a last flag.
package axis_pkg;

    localparam int AXIS_DATA_WIDTH = 512;
    localparam int AXIS_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } axis_occ_e;

    typedef struct packed {
        logic                       last;
        logic [AXIS_DATA_WIDTH-1:0] data;
    } axis_beat_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry FIFO skid buffer with registered upstream ready.
// Entry width is set by the top: data alone, or data plus last when AXIS_RX_LAST_EN is defined.
module axis_skid_buffer
    import axis_pkg::*;
#(
    parameter int ENTRY_W = AXIS_DATA_WIDTH
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [ENTRY_W-1:0] i_entry,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [ENTRY_W-1:0] o_entry
);

    axis_occ_e          r_occ;
    axis_occ_e          w_occ_nxt;
    logic               r_ready;
    logic [ENTRY_W-1:0] r_head;
    logic [ENTRY_W-1:0] r_tail;
    logic               w_push;
    logic               w_pop;

    assign w_push  = i_valid & r_ready;
    assign w_pop   = (r_occ != EMPTY) & i_ready;
    assign o_ready = r_ready;
    assign o_valid = (r_occ != EMPTY);
    assign o_entry = r_head;

    always_comb begin
        w_occ_nxt = r_occ;
        case (r_occ)
            EMPTY: if (w_push) w_occ_nxt = ONE;
            ONE: begin
                if (w_push && !w_pop)      w_occ_nxt = FULL;
                else if (!w_push && w_pop) w_occ_nxt = EMPTY;
            end
            FULL:    if (w_pop) w_occ_nxt = ONE;
            default: w_occ_nxt = EMPTY;
        endcase
    end

    // r_head is always the oldest beat; r_tail only holds the second one while FULL.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_occ   <= EMPTY;
            r_ready <= 1'b0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_occ   <= w_occ_nxt;
            r_ready <= (w_occ_nxt != FULL);
            case (r_occ)
                EMPTY: if (w_push) r_head <= i_entry;
                ONE: begin
                    if (w_push && w_pop) r_head <= i_entry;
                    else if (w_push)     r_tail <= i_entry;
                end
                FULL:    if (w_pop) r_head <= r_tail;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axi_stream_slave.sv
// AXI-Stream receive endpoint: skid buffer, per-message beat counter, protocol checker.
// Define AXIS_RX_LAST_EN to add last tracking (s_last, m_last, msg_done, msg_beats).
module axi_stream_slave
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int CNT_WIDTH  = AXIS_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
`ifdef AXIS_RX_LAST_EN
    input  logic                  s_last,
`endif
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
`ifdef AXIS_RX_LAST_EN
    output logic                  m_last,
    output logic                  msg_done,
    output logic [CNT_WIDTH-1:0]  msg_beats,
`endif
    output logic                  proto_err
);

`ifdef AXIS_RX_LAST_EN
    localparam int ENTRY_W = DATA_WIDTH + 1;
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    logic [ENTRY_W-1:0] w_s_entry;
    logic [ENTRY_W-1:0] w_m_entry;

`ifdef AXIS_RX_LAST_EN
    assign w_s_entry = {s_last, s_data};
    assign m_data    = w_m_entry[DATA_WIDTH-1:0];
    assign m_last    = w_m_entry[DATA_WIDTH];
`else
    assign w_s_entry = s_data;
    assign m_data    = w_m_entry;
`endif

    axis_skid_buffer #(
        .ENTRY_W (ENTRY_W)
    ) u_skid (
        .clk     (clk),
        .resetN  (resetN),
        .i_valid (s_valid),
        .o_ready (s_ready),
        .i_entry (w_s_entry),
        .o_valid (m_valid),
        .i_ready (m_ready),
        .o_entry (w_m_entry)
    );

    // A stalled beat must be held unchanged until accepted.
    logic               r_prev_stall;
    logic [ENTRY_W-1:0] r_prev_entry;
    logic               r_proto_err;
    logic               w_viol;

    assign w_viol    = r_prev_stall & (~s_valid | (w_s_entry != r_prev_entry));
    assign proto_err = r_proto_err;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_prev_stall <= 1'b0;
            r_prev_entry <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            r_prev_stall <= s_valid & ~s_ready;
            r_prev_entry <= w_s_entry;
            if (w_viol) r_proto_err <= 1'b1;
        end
    end

`ifdef AXIS_RX_LAST_EN
    logic                 w_pop;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic [CNT_WIDTH-1:0] r_msg_beats;
    logic                 r_msg_done;

    assign w_pop     = m_valid & m_ready;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign msg_done  = r_msg_done;
    assign msg_beats = r_msg_beats;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_cnt       <= '0;
            r_msg_beats <= '0;
            r_msg_done  <= 1'b0;
        end else begin
            r_msg_done <= w_pop & m_last;
            if (w_pop) begin
                if (m_last) begin
                    r_msg_beats <= w_cnt_inc;
                    r_cnt       <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_stream_slave.sv
// Directed bench for axi_stream_slave with a queue-based reference model checked every cycle.
// Works with or without AXIS_RX_LAST_EN defined.
module tb_axi_stream_slave;

    localparam int DW   = 32;
    localparam int CW   = 16;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk     = 1'b0;
    logic          resetN  = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic          tb_last = 1'b0;
    logic          s_ready;
    logic          m_valid;
    logic          proto_err;
    logic [DW-1:0] m_data;
`ifdef AXIS_RX_LAST_EN
    logic          m_last;
    logic          msg_done;
    logic [CW-1:0] msg_beats;
`endif

    always #5 clk = ~clk;

    axi_stream_slave #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
`ifdef AXIS_RX_LAST_EN
        .s_last    (tb_last),
`endif
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
`ifdef AXIS_RX_LAST_EN
        .m_last    (m_last),
        .msg_done  (msg_done),
        .msg_beats (msg_beats),
`endif
        .proto_err (proto_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of {last,data}, a beat counter and a violation flag.
    logic [DW:0] q[$];
    bit          md_ready;
    int          md_cnt, md_beats;
    bit          md_done, md_err, pv_stall;
    logic [DW:0] pv_beat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        md_ready = 1'b0;
        md_cnt   = 0;
        md_beats = 0;
        md_done  = 1'b0;
        md_err   = 1'b0;
        pv_stall = 1'b0;
        pv_beat  = '0;
    endtask

    task automatic model_step();
        logic [DW:0] cur;
        bit push, pop, lastp;
        int nxt;
`ifdef AXIS_RX_LAST_EN
        cur = {tb_last, s_data};
`else
        cur = {1'b0, s_data};
`endif
        push  = s_valid && md_ready;
        pop   = (q.size() != 0) && m_ready;
        lastp = pop && q[0][DW];
        if (pv_stall && (!s_valid || cur !== pv_beat)) md_err = 1'b1;
        pv_stall = s_valid && !md_ready;
        pv_beat  = cur;
        md_done  = lastp;
        if (pop) begin
            nxt = (md_cnt >= MAXC) ? MAXC : md_cnt + 1;
            if (lastp) begin
                md_beats = nxt;
                md_cnt   = 0;
            end else begin
                md_cnt = nxt;
            end
            void'(q.pop_front());
        end
        if (push) q.push_back(cur);
        md_ready = (q.size() < 2);
    endtask

    task automatic compare();
        chk("s_ready", 64'(s_ready), 64'(md_ready));
        chk("m_valid", 64'(m_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("m_data", 64'(m_data), 64'(q[0][DW-1:0]));
`ifdef AXIS_RX_LAST_EN
            chk("m_last", 64'(m_last), 64'(q[0][DW]));
`endif
        end
`ifdef AXIS_RX_LAST_EN
        chk("msg_done", 64'(msg_done), 64'(md_done));
        chk("msg_beats", 64'(msg_beats), 64'(md_beats));
`endif
        chk("proto_err", 64'(proto_err), 64'(md_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit l);
        s_valid = v;
        s_data  = d;
        tb_last = l;
    endtask

    task automatic pulse_reset();
        resetN = 1'b0;
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
`ifdef AXIS_RX_LAST_EN
        chk("rst_msg_beats", 64'(msg_beats), 64'd0);
        chk("rst_msg_done", 64'(msg_done), 64'd0);
`endif
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        #1;
        chk("s_ready_pre_edge", 64'(s_ready), 64'd0);
        @(negedge clk);
        cycle();
        chk("s_ready_rise", 64'(s_ready), 64'd1);
    endtask

    initial begin
        model_reset();
        drive(0, '0, 0);
        @(negedge clk);
        @(negedge clk);
        pulse_reset();
        chk("idle_m_valid", 64'(m_valid), 64'd0);

        // 8-beat stream at full rate, last on beat 8
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1, DW'(i), i == 8);
            cycle();
            chk("stream_head", 64'(m_data), 64'(i));
            chk("stream_ready", 64'(s_ready), 64'd1);
        end
        drive(0, '0, 0);
        cycle();
        chk("stream_drained", 64'(m_valid), 64'd0);
`ifdef AXIS_RX_LAST_EN
        chk("stream_done", 64'(msg_done), 64'd1);
        chk("stream_beats", 64'(msg_beats), 64'd8);
`endif
        cycle();

        // backpressure: two accepted, third held until space frees
        m_ready = 1'b0;
        drive(1, 32'h1, 0); cycle();
        drive(1, 32'h2, 0); cycle();
        chk("bp_ready_low", 64'(s_ready), 64'd0);
        drive(1, 32'h3, 1); cycle();
        chk("bp_hold_head", 64'(m_data), 64'h1);
        chk("bp_still_low", 64'(s_ready), 64'd0);
        m_ready = 1'b1;
        cycle();
        chk("bp_drain2", 64'(m_data), 64'h2);
        chk("bp_ready_back", 64'(s_ready), 64'd1);
        cycle();
        chk("bp_drain3", 64'(m_data), 64'h3);
        drive(0, '0, 0);
        cycle();
        chk("bp_empty", 64'(m_valid), 64'd0);
`ifdef AXIS_RX_LAST_EN
        chk("bp_beats", 64'(msg_beats), 64'd3);
`endif

        // 5-beat message then a single-beat message
        for (int i = 1; i <= 5; i++) begin
            drive(1, DW'(32'h10 + i), i == 5);
            cycle();
        end
        drive(0, '0, 0);
        cycle();
`ifdef AXIS_RX_LAST_EN
        chk("msg5_done", 64'(msg_done), 64'd1);
        chk("msg5_beats", 64'(msg_beats), 64'd5);
`endif
        cycle();
`ifdef AXIS_RX_LAST_EN
        chk("msg5_done_once", 64'(msg_done), 64'd0);
`endif
        drive(1, 32'h21, 1); cycle();
        drive(0, '0, 0); cycle();
`ifdef AXIS_RX_LAST_EN
        chk("msg1_beats", 64'(msg_beats), 64'd1);
`endif
        cycle();

        // drop s_valid while stalled: sticky error, then reset with 2 beats buffered
        m_ready = 1'b0;
        drive(1, 32'h31, 0); cycle();
        drive(1, 32'h32, 0); cycle();
        drive(1, 32'h99, 0); cycle();
        drive(0, '0, 0);     cycle();
        chk("perr_set", 64'(proto_err), 64'd1);
        repeat (3) cycle();
        chk("perr_sticky", 64'(proto_err), 64'd1);
        chk("full_before_rst", 64'(m_valid), 64'd1);
        pulse_reset();
        chk("perr_cleared", 64'(proto_err), 64'd0);
        m_ready = 1'b1;
        cycle();
        chk("rst_lost_beats", 64'(m_valid), 64'd0);
        drive(1, 32'h41, 0); cycle();
        drive(1, 32'h42, 1); cycle();
        drive(0, '0, 0);     cycle();
`ifdef AXIS_RX_LAST_EN
        chk("post_rst_beats", 64'(msg_beats), 64'd2);
`endif

        // change data while stalled also flags an error
        m_ready = 1'b0;
        drive(1, 32'h51, 0); cycle();
        drive(1, 32'h52, 0); cycle();
        drive(1, 32'h55, 0); cycle();
        chk("perr_clean_hold", 64'(proto_err), 64'd0);
        drive(1, 32'h56, 0); cycle();
        chk("perr_data_change", 64'(proto_err), 64'd1);
        drive(0, '0, 0);
        m_ready = 1'b1;
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
